// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1/8N2 UART transmitter with a programmable bit period.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   baud_tick,
    input  logic                          two_stop,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    state;
    logic [31:0]   cnt, baud_r;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic          two_r, stop2;
    logic          push, pop, bit_end, stop_end;

    assign data_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign overflow   = data_valid && !data_ready;
    assign push       = data_valid && data_ready;
    assign bit_end    = cnt == 32'd0;
    assign stop_end   = bit_end && (!two_r || stop2);
    // Popping at the end of the stop bit chains the next frame with no idle cycle.
    assign pop        = (fifo_count != '0) && (state == IDLE || (state == STOP && stop_end));
    assign busy       = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= (push && !pop) ? fifo_count + 1'b1 :
                          (pop && !push) ? fifo_count - 1'b1 : fifo_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tx     <= 1'b1;
            cnt    <= '0;
            baud_r <= '0;
            two_r  <= 1'b0;
            stop2  <= 1'b0;
            shreg  <= '0;
            idx    <= '0;
        end else if (pop) begin
            state  <= START;
            tx     <= 1'b0;
            shreg  <= mem[rd_ptr];
            cnt    <= baud_tick;
            baud_r <= baud_tick;
            two_r  <= two_stop;
        end else begin
            case (state)
                IDLE: tx <= 1'b1;
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shreg[0];
                        cnt   <= baud_r;
                        idx   <= '0;
                    end else cnt <= cnt - 32'd1;
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= baud_r;
                        if (idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                            stop2 <= 1'b0;
                        end else begin
                            idx   <= idx + 3'd1;
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                        end
                    end else cnt <= cnt - 32'd1;
                end
                STOP: begin
                    if (stop_end) state <= IDLE;
                    else if (bit_end) begin
                        stop2 <= 1'b1;
                        cnt   <= baud_r;
                    end else cnt <= cnt - 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; bytes expected on the line are queued when pushed and matched bit by bit.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] baud_tick = 32'd3;
    logic        two_stop = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_ready, tx, busy, overflow;
    logic [3:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];

    uart_tx_fifo #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .two_stop(two_stop),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit acc);
        data_in = d;
        data_valid = 1'b1;
        #1;
        check("push_ready", data_ready, acc);
        check("push_ovf", overflow, !acc);
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic rx_frame(input string nm, input int bpc, input bit two, output int gap);
        logic [10:0] fr;
        logic [7:0]  d;
        int nb, bad;
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 300) begin
            gap++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check({nm, "_start"}, tx, 0);
            return;
        end
        check({nm, "_sb"}, sb.size() != 0, 1);
        if (sb.size() == 0) return;
        d = sb.pop_front();
        fr = {2'b11, d, 1'b0};
        nb = two ? 11 : 10;
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int c = 0; c < bpc; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx !== fr[b] || busy !== 1'b1) bad++;
            end
            check($sformatf("%s_bit%0d", nm, b), bad, 0);
        end
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk);
        check({nm, "_idle_tx"}, tx, 1);
        check({nm, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int g, lows;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);

        // 0xA5 at 4 cycles/bit, plus the push-to-start latency
        @(posedge clk); #1;
        fork
            push(8'hA5, 1);
            begin
                rx_frame("a5", 4, 0, g);
                check("a5_latency", g, 2);
            end
        join
        idle_check("a5");

        // back-to-back at 1 cycle/bit
        baud_tick = 32'd0;
        @(posedge clk); #1;
        fork
            begin push(8'h00, 1); push(8'hFF, 1); end
            begin
                rx_frame("b2b0", 1, 0, g);
                rx_frame("b2b1", 1, 0, g);
                check("b2b_gap", g, 0);
            end
        join
        idle_check("b2b");

        // two stop bits
        baud_tick = 32'd1;
        two_stop = 1'b1;
        @(posedge clk); #1;
        fork
            push(8'h55, 1);
            rx_frame("n2", 2, 1, g);
        join
        idle_check("n2");
        two_stop = 1'b0;

        // baud change mid-frame takes effect on the next frame only
        baud_tick = 32'd3;
        @(posedge clk); #1;
        fork
            begin
                push(8'h3C, 1);
                push(8'hC3, 1);
                repeat (10) @(posedge clk);
                #1 baud_tick = 32'd7;
            end
            begin
                rx_frame("bd4", 4, 0, g);
                rx_frame("bd8", 8, 0, g);
                check("bd_gap", g, 0);
            end
        join
        idle_check("bd");

        // overflow: ninth push fills the FIFO behind the frame in flight, tenth is dropped
        baud_tick = 32'd100;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 10; i++) push(8'h10 + 8'(i * 7), i < 9);
                #1;
                check("ovf_count", fifo_count, 8);
                check("ovf_ready", data_ready, 0);
                check("ovf_pulse_end", overflow, 0);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame($sformatf("ov%0d", i), 101, 0, g);
                    if (i > 0) check($sformatf("ov%0d_gap", i), g, 0);
                end
            end
        join
        idle_check("ov");
        check("ov_sb_drained", sb.size(), 0);

        // reset during data bit 3 with bytes queued
        baud_tick = 32'd3;
        @(posedge clk); #1;
        fork
            begin push(8'h81, 1); push(8'h42, 1); push(8'h24, 1); end
            begin
                g = 0;
                @(negedge clk);
                while (tx !== 1'b0 && g < 50) begin g++; @(negedge clk); end
                check("rs_start", tx, 0);
                repeat (17) @(negedge clk);
            end
        join
        check("rs_count_mid", fifo_count, 2);
        check("rs_busy_mid", busy, 1);
        rst = 1'b1;
        data_in = 8'h77;
        data_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        data_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rs_tx", tx, 1);
        check("rs_count", fifo_count, 0);
        check("rs_busy", busy, 0);
        check("rs_ready", data_ready, 1);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("rs_quiet", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, number of entries in the transmit FIFO; power of two, 2..64.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: baud_tick  input  32  bit period minus one, in clk cycles; each serial bit lasts baud_tick+1 cycles.
REQ-005 Port: two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-006 Port: data_in  input  8  byte to transmit.
REQ-007 Port: data_valid  input  1  data_in is offered this cycle.
REQ-008 Port: data_ready  output  1  FIFO not full; a push is accepted when data_valid=1 and data_ready=1 at a clock edge.
REQ-009 Port: tx  output  1  serial line, registered, idle high.
REQ-010 Port: busy  output  1  FIFO non-empty or a frame is in progress.
REQ-011 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held.
REQ-012 Port: overflow  output  1  one-cycle pulse when data_valid=1 and data_ready=0.

Function
REQ-013 Frame format: start bit (0), 8 data bits LSB first, no parity, stop bit(s) (1), 8N1 or 8N2.
REQ-014 Bit timing: down-counter loads baud_tick at entry to each bit and reloads at 0; each bit is held for exactly baud_tick+1 cycles; baud_tick=0 gives 1 cycle per bit.
REQ-015 baud_tick and two_stop are captured when a frame starts; changes mid-frame do not affect that frame.
REQ-016 FIFO: circular buffer, pointer wrap modulo FIFO_DEPTH; data_ready = (fifo_count != FIFO_DEPTH), combinational from the count register.
REQ-017 Simultaneous push and pop in one cycle: both take effect; fifo_count unchanged.
REQ-018 Push when full: byte dropped, FIFO unchanged, overflow=1 for that one cycle only.
REQ-019 States: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; if fifo_count>0, pop head into shift register, go to START, drive tx=0 on that edge.
REQ-021 START: after baud_tick+1 cycles, go to DATA, drive bit 0.
REQ-022 DATA: 3-bit index 0..7; after each bit period shift to next bit; after bit 7 go to STOP, drive tx=1.
REQ-023 STOP: hold 1 (two_stop=1: 2x(baud_tick+1) cycles); at end, if FIFO non-empty, pop and enter START directly with no idle cycle between frames; else go to IDLE.
REQ-024 Latency: byte accepted at edge E into an empty FIFO while IDLE -> tx low after edge E+1.
REQ-025 busy = (state != IDLE) or (fifo_count != 0); it falls in the same cycle tx returns to IDLE after the last stop bit.
REQ-026 Frame length: (10 or 11) x (baud_tick+1) cycles, exact, no extra cycles.
REQ-027 32-bit counter arithmetic only; no wrap below 0; baud_tick=32'hFFFFFFFF is legal.

Reset
REQ-028 On rst=1 at an edge: state=IDLE, tx=1, fifo_count=0, pointers=0, overflow=0, busy=0, data_ready=1; FIFO contents discarded.
REQ-029 Reset mid-frame aborts the frame immediately; tx=1 from the following cycle; a push in the reset cycle is ignored.

Verification
REQ-030 baud_tick=3, two_stop=0, push 8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total); busy high throughout.
REQ-031 baud_tick=0, push 8'h00 then 8'hFF back-to-back -> 20 contiguous bit cycles with no idle cycle; second start bit follows the first stop bit directly.
REQ-032 FIFO_DEPTH=8, baud_tick=100, push 10 bytes on consecutive cycles -> first accepted byte starts transmitting; data_ready low once 8 entries are held; each push attempted while data_ready=0 raises overflow for one cycle and its byte is dropped; only accepted bytes are transmitted, in order.
REQ-033 two_stop=1, baud_tick=1, push 8'h55 -> stop level lasts 4 cycles; frame length 22 cycles.
REQ-034 rst asserted during DATA bit 3 with 3 bytes queued -> next cycle tx=1, fifo_count=0, busy=0; no further start bit.
REQ-035 Change baud_tick from 3 to 7 mid-frame -> current frame completes at 4 cycles/bit; the next frame runs at 8 cycles/bit.
